// File: rtl/param_pipeline_adder_if.sv
// Handshake and data bundle for the segmented pipeline adder.
// master: the side that supplies operands and consumes results.
// slave: the adder itself.
interface param_pipeline_adder_if #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  a;
  logic [WIDTH-1:0]  b;
  logic              cin;
  logic              sub;
  logic [STAGES-1:0] stall;
  logic [STAGES-1:0] flush;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  sum;
  logic              cout;
  logic              ovf;
  logic              busy;

  modport master (
    output in_valid, a, b, cin, sub, stall, flush, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, busy
  );

  modport slave (
    input  in_valid, a, b, cin, sub, stall, flush, out_ready,
    output in_ready, out_valid, sum, cout, ovf, busy
  );
endinterface

// File: rtl/param_pipeline_adder.sv
// Segmented pipeline adder/subtractor.
// The WIDTH-bit add is cut into STAGES segments of WIDTH/STAGES bits; stage k
// adds segment k using the carry produced by stage k-1. Every stage has its
// own valid bit, per-stage stall (hold) and flush (kill), and an elastic
// ready chain so backpressure never drops or duplicates an item.
module param_pipeline_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  param_pipeline_adder_if.slave bus
);

  localparam int SEG  = WIDTH / STAGES;
  localparam int LAST = STAGES - 1;

  // Reject segmentations that do not divide the operand evenly.
  generate
    if ((STAGES < 1) || ((WIDTH % STAGES) != 0)) begin : g_bad_params
      $error("param_pipeline_adder: WIDTH must be a positive multiple of STAGES");
    end
  endgenerate

  // Subtraction is a + ~b + 1: b is inverted once at entry and the +1
  // rides in as the stage-0 carry, so every later stage is a plain add.
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;
  assign b_eff   = bus.sub ? ~bus.b : bus.b;
  assign cin_eff = bus.sub ? 1'b1 : bus.cin;

  // Per-stage state gathered into arrays so neighbours can see each other.
  logic [STAGES-1:0] v_pipe;
  logic [STAGES-1:0] c_pipe;
  logic [WIDTH-1:0]  a_pipe   [STAGES];
  logic [WIDTH-1:0]  b_pipe   [STAGES];
  logic [WIDTH-1:0]  res_pipe [STAGES];
  logic              ovf_q;

  // rdy[k]: stage k may take a new item this cycle; rdy[STAGES] is the consumer.
  logic [STAGES:0]   rdy;
  // offer[k]: stage k presents its item downstream (a stalled or flushed
  // item must not be copied forward, otherwise it would be duplicated or
  // survive its kill).
  logic [STAGES-1:0] offer;

  // Ready chain evaluated from the output back towards the input.
  always_comb begin
    rdy         = '0;
    rdy[STAGES] = bus.out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      rdy[k] = !bus.stall[k] && !bus.flush[k] && (!v_pipe[k] || rdy[k+1]);
    end
  end

  // Items that are allowed to leave their stage this cycle.
  always_comb begin
    offer = v_pipe & ~bus.stall & ~bus.flush;
  end

  genvar k;
  generate
    for (k = 0; k < STAGES; k++) begin : g_stage
      logic             uv;
      logic             uc;
      logic [WIDTH-1:0] ua;
      logic [WIDTH-1:0] ub;
      logic [WIDTH-1:0] ur;
      logic [SEG:0]     seg_sum;
      logic [WIDTH-1:0] res_next;

      logic             v_q;
      logic             c_q;
      logic [WIDTH-1:0] a_q;
      logic [WIDTH-1:0] b_q;
      logic [WIDTH-1:0] res_q;

      if (k == 0) begin : g_src_in
        assign uv = bus.in_valid;
        assign ua = bus.a;
        assign ub = b_eff;
        assign uc = cin_eff;
        assign ur = '0;
      end else begin : g_src_prev
        assign uv = offer[k-1];
        assign ua = a_pipe[k-1];
        assign ub = b_pipe[k-1];
        assign uc = c_pipe[k-1];
        assign ur = res_pipe[k-1];
      end

      assign seg_sum = {1'b0, ua[k*SEG +: SEG]}
                     + {1'b0, ub[k*SEG +: SEG]}
                     + {{SEG{1'b0}}, uc};

      // Merge this stage's segment into the partial result from upstream.
      always_comb begin
        res_next                = ur;
        res_next[k*SEG +: SEG]  = seg_sum[SEG-1:0];
      end

      // Stage register: reset, then flush, then stall, then elastic load.
      always_ff @(posedge clk) begin
        if (rst) begin
          v_q   <= 1'b0;
          c_q   <= 1'b0;
          a_q   <= '0;
          b_q   <= '0;
          res_q <= '0;
        end else if (bus.flush[k]) begin
          v_q   <= 1'b0;
        end else if (bus.stall[k]) begin
          v_q   <= v_q;
        end else if (rdy[k]) begin
          v_q   <= uv;
          if (uv) begin
            a_q   <= ua;
            b_q   <= ub;
            c_q   <= seg_sum[SEG];
            res_q <= res_next;
          end else begin
            res_q <= res_q;
          end
        end else begin
          v_q   <= v_q;
        end
      end

      // The last stage also captures signed overflow as it completes the MSB.
      if (k == LAST) begin : g_ovf
        logic ovf_next;
        assign ovf_next = (ua[WIDTH-1] == ub[WIDTH-1]) &&
                          (res_next[WIDTH-1] != ua[WIDTH-1]);

        // Overflow flag follows the same load rules as the last stage.
        always_ff @(posedge clk) begin
          if (rst) begin
            ovf_q <= 1'b0;
          end else if (bus.flush[k] || bus.stall[k]) begin
            ovf_q <= ovf_q;
          end else if (rdy[k] && uv) begin
            ovf_q <= ovf_next;
          end else begin
            ovf_q <= ovf_q;
          end
        end
      end

      assign v_pipe[k]   = v_q;
      assign c_pipe[k]   = c_q;
      assign a_pipe[k]   = a_q;
      assign b_pipe[k]   = b_q;
      assign res_pipe[k] = res_q;
    end
  endgenerate

  // Results come straight from the last stage's registers.
  assign bus.in_ready  = rdy[0] && !rst;
  assign bus.out_valid = v_pipe[LAST];
  assign bus.sum       = res_pipe[LAST];
  assign bus.cout      = c_pipe[LAST];
  assign bus.ovf       = ovf_q;
  assign bus.busy      = |v_pipe;

endmodule

// File: tb/tb_param_pipeline_adder.sv
// Directed bench for param_pipeline_adder (WIDTH=32, STAGES=4).
module tb_param_pipeline_adder;

  logic clk = 1'b0;
  logic rst;

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  param_pipeline_adder_if #(.WIDTH(32), .STAGES(4)) bus ();

  param_pipeline_adder #(.WIDTH(32), .STAGES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  localparam logic [31:0] B_CONST = 32'h0F0F_0F0F;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] got [$];
  logic [31:0] exp_q [$];
  logic        acc;
  int          idx;
  int          t;

  function automatic logic [31:0] item_a(input int i);
    return 32'h1000_0000 + (i * 32'h0101_0101);
  endfunction

  function automatic logic [31:0] item_sum(input int i);
    return item_a(i) + B_CONST;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: sample handshakes at the falling edge, return just after the rise.
  task automatic cyc(output logic accepted);
    @(negedge clk);
    accepted = bus.in_valid && bus.in_ready;
    if (bus.out_valid && bus.out_ready) got.push_back(bus.sum);
    @(posedge clk);
    #1;
  endtask

  task automatic set_item(input int i);
    bus.a   = item_a(i);
    bus.b   = B_CONST;
    bus.cin = 1'b0;
    bus.sub = 1'b0;
  endtask

  task automatic check_stream(input string tag);
    chk({tag, "_count"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got.size()) chk($sformatf("%s_item%0d", tag, i), got[i], exp_q[i]);
      else                chk($sformatf("%s_item%0d", tag, i), 32'hxxxx_xxxx, exp_q[i]);
    end
  endtask

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.a         = 32'h0000_0000;
    bus.b         = 32'h0000_0000;
    bus.cin       = 1'b0;
    bus.sub       = 1'b0;
    bus.stall     = 4'b0000;
    bus.flush     = 4'b0000;
    bus.out_ready = 1'b1;

    // Reset state.
    repeat (3) cyc(acc);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_sum", bus.sum, 32'h0000_0000);
    chk("rst_cout", bus.cout, 0);
    chk("rst_ovf", bus.ovf, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", bus.in_ready, 1);
    cyc(acc);

    // Full carry ripple: 0xFFFFFFFF + 1, latency exactly 4.
    bus.a = 32'hFFFF_FFFF; bus.b = 32'h0000_0001; bus.cin = 1'b0; bus.sub = 1'b0;
    bus.in_valid = 1'b1;
    cyc(acc);
    chk("t1_accept", acc, 1);
    bus.in_valid = 1'b0;
    cyc(acc); cyc(acc);
    chk("t1_not_early", bus.out_valid, 0);
    cyc(acc);
    chk("t1_valid", bus.out_valid, 1);
    chk("t1_sum", bus.sum, 32'h0000_0000);
    chk("t1_cout", bus.cout, 1);
    chk("t1_ovf", bus.ovf, 0);
    repeat (3) cyc(acc);

    // Back-to-back: overflow, subtract (cin ignored), plain add.
    bus.in_valid = 1'b1;
    bus.a = 32'h7FFF_FFFF; bus.b = 32'h0000_0001; bus.cin = 1'b0; bus.sub = 1'b0;
    cyc(acc);
    bus.a = 32'h0000_0005; bus.b = 32'h0000_0007; bus.cin = 1'b1; bus.sub = 1'b1;
    cyc(acc);
    bus.a = 32'h1234_5678; bus.b = 32'h1111_1111; bus.cin = 1'b0; bus.sub = 1'b0;
    cyc(acc);
    bus.in_valid = 1'b0;
    cyc(acc);
    chk("t2a_valid", bus.out_valid, 1);
    chk("t2a_sum", bus.sum, 32'h8000_0000);
    chk("t2a_ovf", bus.ovf, 1);
    chk("t2a_cout", bus.cout, 0);
    cyc(acc);
    chk("t2b_sum", bus.sum, 32'hFFFF_FFFE);
    chk("t2b_cout", bus.cout, 0);
    chk("t2b_ovf", bus.ovf, 0);
    cyc(acc);
    chk("t2c_sum", bus.sum, 32'h2345_6789);
    chk("t2c_cout", bus.cout, 0);
    chk("t2c_ovf", bus.ovf, 0);
    repeat (4) cyc(acc);

    // Stream with a two-cycle stall on stage 1.
    got.delete(); exp_q.delete();
    for (int i = 0; i < 10; i++) exp_q.push_back(item_sum(i));
    idx = 0; t = 0;
    bus.in_valid = 1'b1;
    while (idx < 10 && t < 100) begin
      set_item(idx);
      bus.stall = (t == 4 || t == 5) ? 4'b0010 : 4'b0000;
      #1;
      if (t == 4 || t == 5) chk($sformatf("stall_in_ready_t%0d", t), bus.in_ready, 0);
      cyc(acc);
      if (acc) idx++;
      t++;
    end
    chk("stall_accepted", idx, 10);
    bus.in_valid = 1'b0; bus.stall = 4'b0000;
    repeat (8) cyc(acc);
    check_stream("stall");

    // Stream with a flush of stage 2 while it holds item 2.
    got.delete(); exp_q.delete();
    for (int i = 0; i < 8; i++) if (i != 2) exp_q.push_back(item_sum(i));
    idx = 0; t = 0;
    bus.in_valid = 1'b1;
    while (idx < 8 && t < 100) begin
      set_item(idx);
      bus.flush = (t == 5) ? 4'b0100 : 4'b0000;
      #1;
      if (t == 5) chk("flush_in_ready", bus.in_ready, 0);
      cyc(acc);
      if (acc) idx++;
      t++;
    end
    bus.in_valid = 1'b0; bus.flush = 4'b0000;
    repeat (8) cyc(acc);
    check_stream("flush");

    // Backpressure: consumer stalls until the pipe is full.
    got.delete(); exp_q.delete();
    for (int i = 0; i < 6; i++) exp_q.push_back(item_sum(i));
    bus.out_ready = 1'b0;
    idx = 0;
    bus.in_valid = 1'b1;
    for (int c = 0; c < 6; c++) begin
      set_item(idx);
      cyc(acc);
      if (acc) idx++;
    end
    set_item(idx);
    #1;
    chk("bp_accepted", idx, 4);
    chk("bp_in_ready", bus.in_ready, 0);
    chk("bp_out_valid", bus.out_valid, 1);
    chk("bp_sum_hold0", bus.sum, item_sum(0));
    cyc(acc);
    chk("bp_out_valid_hold", bus.out_valid, 1);
    chk("bp_sum_hold1", bus.sum, item_sum(0));
    bus.out_ready = 1'b1;
    t = 0;
    while (idx < 6 && t < 50) begin
      set_item(idx);
      cyc(acc);
      if (acc) idx++;
      t++;
    end
    bus.in_valid = 1'b0;
    repeat (8) cyc(acc);
    check_stream("bp");

    // Reset with three items in flight discards them.
    got.delete();
    bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_item(20 + i);
      cyc(acc);
    end
    bus.in_valid = 1'b0;
    chk("rst_mid_busy_before", bus.busy, 1);
    rst = 1'b1;
    cyc(acc);
    chk("rst_mid_out_valid", bus.out_valid, 0);
    chk("rst_mid_busy", bus.busy, 0);
    chk("rst_mid_in_ready", bus.in_ready, 0);
    rst = 1'b0;
    repeat (8) cyc(acc);
    chk("rst_mid_no_output", got.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/param_pipeline_adder.md
PARAM_PIPELINE_ADDER -- requirements
Module: param_pipeline_adder

Interface
REQ-001 The block SHALL take parameter WIDTH, default 32: operand and sum width in bits.
REQ-002 The block SHALL take parameter STAGES, default 4: pipeline depth; each stage adds one WIDTH/STAGES-bit segment; WIDTH not a multiple of STAGES SHALL be rejected at elaboration.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 in_valid  in  1  operand set present on a, b, cin, sub.
REQ-006 in_ready  out  1  stage 0 can accept this cycle.
REQ-007 a, b  in  WIDTH  operands.
REQ-008 cin  in  1  carry-in, used when sub=0.
REQ-009 sub  in  1  0: a+b+cin; 1: a-b.
REQ-010 stall  in  STAGES  per-stage hold request, bit k = stage k.
REQ-011 flush  in  STAGES  per-stage kill request, bit k = stage k.
REQ-012 out_valid  out  1  result valid (stage STAGES-1 occupied).
REQ-013 out_ready  in  1  consumer accepts result this cycle.
REQ-014 sum  out  WIDTH  result.
REQ-015 cout  out  1  carry out of MSB (sub=1: 1 = no borrow).
REQ-016 ovf  out  1  signed two's-complement overflow.
REQ-017 busy  out  1  any stage valid.

Function
REQ-018 sub=1 SHALL compute a + ~b + 1, ignoring cin; inversion of b done at stage 0 entry.
REQ-019 Stage k SHALL hold valid bit v[k], carry into segment k+1, low (k+1)*SEG result bits, and unprocessed upper operand bits; segment k adds a-seg + b-seg + carry-in from stage k-1 (stage 0: cin or 1).
REQ-020 Stage k ready: r[k] = !stall[k] && !flush[k] && (!v[k] || (v[k] && r[k+1])), with r[STAGES] = out_ready; in_ready = r[0].
REQ-021 Stage k SHALL load from upstream when upstream valid and r[k]; unchanged when stall[k]=1 (contents and v[k] held); otherwise v[k] cleared if its item moved on and nothing entered.
REQ-022 flush[k]=1 SHALL clear v[k] at next edge and has priority over stall[k] and load; because r[k]=0, upstream item is held, never lost.
REQ-023 Simultaneous flush on multiple stages SHALL clear each flagged stage independently.
REQ-024 Latency with no stall/flush/backpressure: operand accepted in cycle n appears with out_valid=1 in cycle n+STAGES; throughput one result per cycle.
REQ-025 Results SHALL leave in acceptance order; no duplication or drop except by flush.
REQ-026 out_valid=1 and out_ready=0 SHALL hold sum, cout, ovf stable until accepted.
REQ-027 ovf SHALL equal (a_msb == b_eff_msb) && (sum_msb != a_msb), b_eff = sub ? ~b : b, computed in last stage.
REQ-028 Datapath of an invalid stage is don't-care; outputs sum/cout/ovf meaningful only when out_valid=1; no high-impedance values anywhere.
REQ-029 busy SHALL be OR of all v[k].

Reset
REQ-030 rst=1 SHALL clear all v[k] at next edge, overriding stall and flush; out_valid=0, busy=0, sum=0, cout=0, ovf=0.
REQ-031 in_ready SHALL be 0 while rst=1; in-flight items at reset are discarded.

Verification (WIDTH=32, STAGES=4)
REQ-032 a=0xFFFFFFFF, b=1, cin=0, sub=0 accepted cycle 10 -> cycle 14: out_valid=1, sum=0, cout=1, ovf=0.
REQ-033 Back-to-back 0x7FFFFFFF+1, 5-7 (sub=1), 0x12345678+0x11111111 cycles 20-22 -> cycles 24-26: 0x80000000 ovf=1; 0xFFFFFFFE cout=0; 0x23456789.
REQ-034 Continuous stream from cycle 30, stall[1]=1 cycles 40-41 -> stages 0-1 hold two cycles, in_ready=0 those cycles, two-cycle bubble at output, no item lost or duplicated.
REQ-035 Stream from cycle 50, flush[2]=1 in cycle 55 -> exactly the one item in stage 2 never appears; following items continue in order.
REQ-036 out_ready=0 cycles 60-63 with full pipe -> out_valid stays 1, sum stable, in_ready=0 once all four stages full; release drains in order.
REQ-037 rst=1 in cycle 70 with three items in flight -> cycle 71 out_valid=0, busy=0; those items never appear.
